// File: rtl/mips_if_pkg.sv
// Shared types and defaults for the prefetching MIPS fetch stage.
// Holds default widths, the NOP encoding and the queue/tag entry layouts.
package mips_if_pkg;

    localparam int          IF_ADDR_W = 32;
    localparam int          IF_DATA_W = 32;
    localparam logic [31:0] NOP       = 32'h0000_0000;

    typedef struct packed {
        logic [IF_ADDR_W-1:0] pc;
        logic [IF_DATA_W-1:0] instr;
    } fq_entry_t;

    typedef struct packed {
        logic [IF_ADDR_W-1:0] pc;
        logic                 epoch;
    } tag_t;

endpackage

// File: rtl/mips_if_fifo.sv
// Synchronous FIFO with flush, used for request tags and fetched instructions.
// Ports: clk, rst_n (async low), flush, push/wdata, pop/rdata, full, empty, count.
module mips_if_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [PTR_W:0]   count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_q, wr_d;
    logic [PTR_W-1:0] rd_q, rd_d;
    logic [PTR_W:0]   cnt_q, cnt_d;
    logic             do_push;
    logic             do_pop;

    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == (PTR_W+1)'(DEPTH));
    assign count   = cnt_q;
    assign rdata   = mem_q[rd_q];
    assign do_pop  = pop && !empty;
    // A full queue may still accept a push when the head leaves this cycle.
    assign do_push = push && (!full || do_pop);

    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (flush) begin
            wr_d  = '0;
            rd_d  = '0;
            cnt_d = '0;
        end else begin
            if (do_push) wr_d = wr_q + PTR_W'(1);
            if (do_pop)  rd_d = rd_q + PTR_W'(1);
            unique case ({do_push, do_pop})
                2'b10:   cnt_d = cnt_q + (PTR_W+1)'(1);
                2'b01:   cnt_d = cnt_q - (PTR_W+1)'(1);
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem_q[wr_q] <= wdata;
    end

endmodule

// File: rtl/mips_if_prefetch.sv
// Prefetching fetch stage: PC, request port, tag FIFO and fetch queue.
// Ports: clk, rst (async low), branch/pc_branch, stall_D, imem req/rsp, F-stage head outputs.
module mips_if_prefetch
    import mips_if_pkg::*;
#(
    parameter int                ADDR_W   = IF_ADDR_W,
    parameter int                DATA_W   = IF_DATA_W,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                FQ_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              branch,
    input  logic [ADDR_W-1:0] pc_branch,
    input  logic              stall_D,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [ADDR_W-1:0] imem_req_addr,
    input  logic              imem_rsp_valid,
    input  logic [DATA_W-1:0] imem_rsp_data,
    output logic              valid_F,
    output logic [DATA_W-1:0] Instruction_F,
    output logic [ADDR_W-1:0] Pc_F,
    output logic [ADDR_W-1:0] PcPlus4_F
);

    localparam int CNT_W = $clog2(FQ_DEPTH) + 1;

    logic [ADDR_W-1:0]        pc_q, pc_d;
    logic                     epoch_q, epoch_d;
    logic [CNT_W-1:0]         inflight;
    logic [CNT_W-1:0]         fq_count;
    logic [CNT_W:0]           credit_used;
    logic                     req_fire;
    logic                     rsp_take;
    logic                     fq_push;
    logic                     fq_pop;
    logic                     tag_empty, tag_full;
    logic                     fq_empty, fq_full;
    logic [ADDR_W:0]          tag_wdata, tag_rdata;
    logic [ADDR_W+DATA_W-1:0] fq_wdata, fq_rdata;

    // Every outstanding request owns a queue slot, so the queue never overflows.
    assign credit_used    = {1'b0, inflight} + {1'b0, fq_count};
    assign imem_req_valid = rst && !branch
                          && (credit_used < (CNT_W+1)'(FQ_DEPTH));
    assign imem_req_addr  = pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;

    // Responses with no outstanding tag are protocol errors and are ignored.
    assign rsp_take  = imem_rsp_valid && !tag_empty;
    assign tag_wdata = {pc_q, epoch_q};
    assign fq_wdata  = {tag_rdata[ADDR_W:1], imem_rsp_data};
    // Stale-epoch responses and any response during a redirect are dropped.
    assign fq_push   = rsp_take && (tag_rdata[0] == epoch_q) && !branch
                     && (!fq_full || fq_pop);
    assign fq_pop    = valid_F && !stall_D;

    always_comb begin
        pc_d    = pc_q;
        epoch_d = epoch_q;
        if (branch) begin
            pc_d    = pc_branch & ~ADDR_W'(3);
            epoch_d = ~epoch_q;
        end else if (req_fire) begin
            pc_d = pc_q + ADDR_W'(4);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q    <= RESET_PC;
            epoch_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            epoch_q <= epoch_d;
        end
    end

    // Tags are never flushed; their count is the in-flight request count.
    mips_if_fifo #(
        .WIDTH (ADDR_W + 1),
        .DEPTH (FQ_DEPTH)
    ) u_tag_fifo (
        .clk   (clk),
        .rst_n (rst),
        .flush (1'b0),
        .push  (req_fire && !tag_full),
        .wdata (tag_wdata),
        .pop   (rsp_take),
        .rdata (tag_rdata),
        .full  (tag_full),
        .empty (tag_empty),
        .count (inflight)
    );

    mips_if_fifo #(
        .WIDTH (ADDR_W + DATA_W),
        .DEPTH (FQ_DEPTH)
    ) u_fetch_q (
        .clk   (clk),
        .rst_n (rst),
        .flush (branch),
        .push  (fq_push),
        .wdata (fq_wdata),
        .pop   (fq_pop),
        .rdata (fq_rdata),
        .full  (fq_full),
        .empty (fq_empty),
        .count (fq_count)
    );

    assign valid_F       = !fq_empty;
    assign Instruction_F = valid_F ? fq_rdata[DATA_W-1:0] : DATA_W'(NOP);
    assign Pc_F          = fq_rdata[ADDR_W+DATA_W-1:DATA_W];
    assign PcPlus4_F     = Pc_F + ADDR_W'(4);

endmodule

// File: tb/tb_mips_if_prefetch.sv
// Scoreboard bench for mips_if_prefetch with a fixed-latency memory model.
// A second instance with RESET_PC=0xFFFF_FFFC checks the PC wrap after reset.
module tb_mips_if_prefetch;
    import mips_if_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, branch, stall_D, imem_req_ready, imem_rsp_valid;
    logic [31:0] pc_branch, imem_rsp_data;

    logic        a_req_valid, a_valid;
    logic [31:0] a_req_addr, a_instr, a_pc, a_pc4;
    logic        b_req_valid, b_valid;
    logic [31:0] b_req_addr, b_instr, b_pc, b_pc4;

    mips_if_prefetch u_dut (
        .clk            (clk),
        .rst            (rst),
        .branch         (branch),
        .pc_branch      (pc_branch),
        .stall_D        (stall_D),
        .imem_req_valid (a_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (a_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .valid_F        (a_valid),
        .Instruction_F  (a_instr),
        .Pc_F           (a_pc),
        .PcPlus4_F      (a_pc4)
    );

    mips_if_prefetch #(.RESET_PC(32'hFFFF_FFFC)) u_dut_wrap (
        .clk            (clk),
        .rst            (rst),
        .branch         (branch),
        .pc_branch      (pc_branch),
        .stall_D        (stall_D),
        .imem_req_valid (b_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (b_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .valid_F        (b_valid),
        .Instruction_F  (b_instr),
        .Pc_F           (b_pc),
        .PcPlus4_F      (b_pc4)
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mem_t;

    mem_t        mem_q[$];
    logic [31:0] exp_q[$];

    int          n_chk, n_fail;
    int          cyc, lat, fires, n2, first_req, first_v;
    bit          v2_seen;
    logic [31:0] mpc, pcb_n, last_fire;
    logic        br_n, stall_n, rdy_n, last_vf, last_rv;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return a ^ 32'hDEAD_BEEF;
    endfunction

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)",
                     tag, got, exp, cyc);
        end
    endtask

    task automatic step();
        logic [31:0] e;
        @(negedge clk);
        branch         = br_n;
        pc_branch      = pcb_n;
        br_n           = 1'b0;
        stall_D        = stall_n;
        imem_req_ready = rdy_n;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = instr_of(mem_q[0].addr);
            void'(mem_q.pop_front());
        end
        #1;
        last_vf = a_valid;
        last_rv = a_req_valid;
        if (!a_valid) check("nop_when_empty", a_instr, NOP);
        if (branch) begin
            check("req_blocked_on_branch", {31'b0, a_req_valid}, 32'd0);
            exp_q.delete();
            mpc = pc_branch & 32'hFFFF_FFFC;
        end else if (a_valid && !stall_D) begin
            if (exp_q.size() == 0) begin
                check("sb_underflow", exp_q.size(), 32'd1);
            end else begin
                e = exp_q.pop_front();
                check("Pc_F", a_pc, e);
                check("Instruction_F", a_instr, instr_of(e));
                check("PcPlus4_F", a_pc4, e + 32'd4);
            end
        end
        if (a_req_valid && imem_req_ready) begin
            check("req_addr", a_req_addr, mpc);
            exp_q.push_back(mpc);
            mem_q.push_back('{mpc, cyc + lat});
            last_fire = mpc;
            mpc       = mpc + 32'd4;
            fires++;
            if (first_req < 0) first_req = cyc;
        end
        if (a_valid && first_v < 0) first_v = cyc;
        if (b_req_valid && imem_req_ready && n2 < 2) begin
            check("wrap_req_addr", b_req_addr,
                  (n2 == 0) ? 32'hFFFF_FFFC : 32'h0000_0000);
            n2++;
        end
        if (b_valid && !v2_seen) begin
            v2_seen = 1'b1;
            check("wrap_Pc_F", b_pc, 32'hFFFF_FFFC);
            check("wrap_PcPlus4_F", b_pc4, 32'h0000_0000);
        end
        cyc++;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #1;
        check("rst_valid_F", {31'b0, a_valid}, 32'd0);
        check("rst_Instruction_F", a_instr, NOP);
        check("rst_req_valid", {31'b0, a_req_valid}, 32'd0);
        mem_q.delete();
        exp_q.delete();
        mpc            = 32'h0;
        first_req      = -1;
        first_v        = -1;
        br_n           = 1'b0;
        branch         = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_req_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        n_chk = 0; n_fail = 0; cyc = 0; lat = 1; fires = 0; n2 = 0;
        v2_seen = 1'b0; mpc = '0; last_fire = '0;
        rst = 1'b0; branch = 1'b0; pc_branch = '0; stall_D = 1'b0;
        imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
        br_n = 1'b0; pcb_n = '0; stall_n = 1'b0; rdy_n = 1'b1;
        #2;

        // Streaming with a 1-cycle memory
        do_reset();
        repeat (12) step();
        check("first_valid_latency", first_v - first_req, 32'd2);

        // Decode stalled: credits cap issue at queue depth
        do_reset();
        stall_n = 1'b1;
        fires   = 0;
        repeat (10) step();
        check("stall_fires", fires, 32'd4);
        check("stall_req_valid", {31'b0, last_rv}, 32'd0);
        stall_n = 1'b0;
        fires   = 0;
        repeat (8) step();
        check("resume_issue", {31'b0, fires > 0}, 32'd1);

        // Redirect with two requests in flight on a 3-cycle memory
        do_reset();
        lat = 3;
        repeat (2) step();
        br_n  = 1'b1;
        pcb_n = 32'h0F0F_0F03;
        step();
        step();
        check("redirect_addr", last_fire, 32'h0F0F_0F00);
        repeat (12) step();

        // Response and redirect in the same cycle, two entries queued
        do_reset();
        lat     = 1;
        stall_n = 1'b1;
        repeat (3) step();
        br_n  = 1'b1;
        pcb_n = 32'h0000_0100;
        step();
        step();
        check("flush_valid_F", {31'b0, last_vf}, 32'd0);
        stall_n = 1'b0;
        repeat (8) step();

        // Asynchronous reset in mid-stream
        do_reset();
        lat = 3;
        repeat (6) step();
        check("pre_rst_valid", {31'b0, last_vf}, 32'd1);
        #2;
        do_reset();
        lat     = 1;
        stall_n = 1'b1;
        fires   = 0;
        repeat (10) step();
        check("post_rst_fires", fires, 32'd4);
        stall_n = 1'b0;
        repeat (10) step();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
